// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one synchronous word-addressed memory port (IDLE/ACCESS/RESP).
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise master 0 has fixed priority.
module bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_data_w,
  input  logic [3:0]        m0_mask_w,
  output logic              m0_ack,
  output logic [31:0]       m0_data_r,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_data_w,
  input  logic [3:0]        m1_mask_w,
  output logic              m1_ack,
  output logic [31:0]       m1_data_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_w,
  output logic [3:0]        mem_mask_w,
  input  logic [31:0]       mem_data_r
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              owner_r;
  logic              grant_s;
  logic              winner_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_data_s;
  logic [3:0]        sel_mask_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_data_w_r;
  logic [3:0]        mem_mask_w_r;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic              last_r;
`endif

  // Next-state and grant decision; RESP hands straight over to the other master.
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    winner_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req && m1_req) begin
          grant_s      = 1'b1;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
          winner_s     = ~last_r;
`else
          winner_s     = 1'b0;
`endif
          next_state_s = ACCESS;
        end else if (m0_req) begin
          grant_s      = 1'b1;
          winner_s     = 1'b0;
          next_state_s = ACCESS;
        end else if (m1_req) begin
          grant_s      = 1'b1;
          winner_s     = 1'b1;
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        next_state_s = RESP;
      end
      RESP: begin
        // The owner's req is still high by protocol, so only the other master counts.
        if (owner_r ? m0_req : m1_req) begin
          grant_s      = 1'b1;
          winner_s     = ~owner_r;
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Payload mux for the master being granted this cycle.
  always_comb begin
    sel_addr_s = m0_addr;
    sel_data_s = m0_data_w;
    sel_mask_s = m0_mask_w;
    if (winner_s) begin
      sel_addr_s = m1_addr;
      sel_data_s = m1_data_w;
      sel_mask_s = m1_mask_w;
    end else begin
      sel_addr_s = m0_addr;
      sel_data_s = m0_data_w;
      sel_mask_s = m0_mask_w;
    end
  end

  // State, ownership and registered memory port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_w_r <= 32'd0;
      mem_mask_w_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (grant_s) begin
        owner_r      <= winner_s;
        mem_addr_r   <= sel_addr_s;
        mem_data_w_r <= sel_data_s;
        mem_mask_w_r <= sel_mask_s;
      end else if (state_r == ACCESS) begin
        mem_mask_w_r <= 4'd0;
      end
    end
  end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  // Most recently granted master; reset to 1 so master 0 wins the first contest.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (grant_s) begin
      last_r <= winner_s;
    end
  end
`endif

  assign mem_addr   = mem_addr_r;
  assign mem_data_w = mem_data_w_r;
  assign mem_mask_w = mem_mask_w_r;
  assign m0_ack     = (state_r == RESP) && !owner_r;
  assign m1_ack     = (state_r == RESP) && owner_r;
  assign m0_data_r  = mem_data_r;
  assign m1_data_r  = mem_data_r;

endmodule
